fetch_decode_queue: RTL and testbench

- Parametrised successor to the single IF/ID register between i_fetch and i_decode.
- Elastic instruction queue: fetch pushes {instr, npc} pairs, decode pops them.
- Supports configurable depth, backpressure to fetch, and whole-queue flush on branch redirect (EX_MEM_PCSrc).
- Empty queue presents a NOP bubble to decode.

---
 rtl/fetch_decode_queue.sv | 97 +++++++++
 tb/tb_fetch_decode_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: elastic IF/ID instruction queue.
// Fetch pushes {instr, npc} pairs, decode pops them from the head. Flush
// (branch redirect) discards every entry. When empty, decode sees a NOP bubble.
module fetch_decode_queue #(
   parameter int unsigned        INSTR_W  = 32,
   parameter int unsigned        NPC_W    = 32,
   parameter int unsigned        DEPTH    = 4,
   parameter logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_valid,
   input  logic [INSTR_W-1:0]           push_instr,
   input  logic [NPC_W-1:0]             push_npc,
   output logic                         push_ready,
   input  logic                         flush,
   input  logic                         pop,
   output logic                         out_valid,
   output logic [INSTR_W-1:0]           out_instr,
   output logic [NPC_W-1:0]             out_npc,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow_err
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [INSTR_W-1:0] r_mem_instr [DEPTH];
   logic [NPC_W-1:0]   r_mem_npc   [DEPTH];
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_overflow_err;

   logic w_full;
   logic w_empty;
   logic w_push_acc;
   logic w_pop_acc;

   assign w_full     = (r_count == FULL_CNT);
   assign w_empty    = (r_count == '0);
   // Flush overrides both sides; a pop on an empty queue is simply not accepted.
   assign w_push_acc = push_valid && !w_full && !flush;
   assign w_pop_acc  = pop && !w_empty && !flush;

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk) begin
      if (w_push_acc) begin
         r_mem_instr[r_wr_ptr] <= push_instr;
         r_mem_npc[r_wr_ptr]   <= push_npc;
      end
   end

   // Pointer and occupancy tracking; pointers wrap naturally as DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_pop_acc)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (w_push_acc && !w_pop_acc)
            r_count <= r_count + CNT_W'(1);
         else if (w_pop_acc && !w_push_acc)
            r_count <= r_count - CNT_W'(1);
      end
   end

   // Sticky overflow flag: fetch offered an entry while full and no flush was pending.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_overflow_err <= 1'b0;
      else if (push_valid && w_full && !flush)
         r_overflow_err <= 1'b1;
   end

   // Outputs come from registered state only; head is masked to a bubble when empty.
   always_comb begin
      push_ready   = !w_full;
      out_valid    = !w_empty;
      count        = r_count;
      overflow_err = r_overflow_err;
      out_instr    = NOP_WORD;
      out_npc      = '0;
      if (!w_empty) begin
         out_instr = r_mem_instr[r_rd_ptr];
         out_npc   = r_mem_npc[r_rd_ptr];
      end
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Directed self-checking bench for fetch_decode_queue (DEPTH=4).
module tb_fetch_decode_queue;

   logic        clk;
   logic        rst_n;
   logic        push_valid;
   logic [31:0] push_instr;
   logic [31:0] push_npc;
   logic        push_ready;
   logic        flush;
   logic        pop;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_npc;
   logic [2:0]  count;
   logic        overflow_err;

   int n_cmp;
   int n_err;

   fetch_decode_queue #(
      .INSTR_W (32),
      .NPC_W   (32),
      .DEPTH   (4),
      .NOP_WORD(32'h0000_0000)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_valid  (push_valid),
      .push_instr  (push_instr),
      .push_npc    (push_npc),
      .push_ready  (push_ready),
      .flush       (flush),
      .pop         (pop),
      .out_valid   (out_valid),
      .out_instr   (out_instr),
      .out_npc     (out_npc),
      .count       (count),
      .overflow_err(overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      push_valid = 1'b0;
      push_instr = '0;
      push_npc   = '0;
      flush      = 1'b0;
      pop        = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic push_one(input logic [31:0] ins, input logic [31:0] npc);
      push_valid = 1'b1;
      push_instr = ins;
      push_npc   = npc;
      step();
      push_valid = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL reset_push_ready cyc%0d: got %b expected 1", i, push_ready); end
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid cyc%0d: got %b expected 0", i, out_valid); end
         n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr cyc%0d: got %h expected 00000000", i, out_instr); end
         n_cmp++; if (out_npc !== 32'h0) begin n_err++; $display("FAIL reset_out_npc cyc%0d: got %h expected 0", i, out_npc); end
         n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count cyc%0d: got %0d expected 0", i, count); end
         n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_overflow cyc%0d: got %b expected 0", i, overflow_err); end
         // pop on empty must be ignored
         pop = (i >= 3);
         step();
      end
      pop = 1'b0;
   endtask

   task automatic test_fill_drain();
      logic [31:0] ins [4];
      ins[0] = 32'h8C010004; ins[1] = 32'h8C020008; ins[2] = 32'h00221820; ins[3] = 32'hAC03000C;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push_one(ins[i], 32'(4 * (i + 1)));
         n_cmp++; if (count !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count push%0d: got %0d expected %0d", i, count, i + 1); end
         n_cmp++; if (out_instr !== 32'h8C010004) begin n_err++; $display("FAIL fill_head push%0d: got %h expected 8c010004", i, out_instr); end
      end
      n_cmp++; if (push_ready !== 1'b0) begin n_err++; $display("FAIL fill_push_ready: got %b expected 0", push_ready); end
      n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL fill_overflow_pre: got %b expected 0", overflow_err); end
      push_one(32'hDEADBEEF, 32'd20);
      n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL overflow_set: got %b expected 1", overflow_err); end
      n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL overflow_count: got %0d expected 4", count); end
      pop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         n_cmp++; if (out_instr !== ins[i]) begin n_err++; $display("FAIL drain_instr %0d: got %h expected %h", i, out_instr, ins[i]); end
         n_cmp++; if (out_npc !== 32'(4 * (i + 1))) begin n_err++; $display("FAIL drain_npc %0d: got %0d expected %0d", i, out_npc, 4 * (i + 1)); end
         step();
      end
      pop = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL drain_out_instr: got %h expected 00000000", out_instr); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL drain_count: got %0d expected 0", count); end
      n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL overflow_sticky: got %b expected 1", overflow_err); end
   endtask

   task automatic test_wrap();
      do_reset();
      pop = 1'b1;
      for (int i = 1; i <= 10; i++) begin
         push_valid = 1'b1;
         push_instr = 32'(i);
         push_npc   = 32'(4 * i);
         step();
         n_cmp++; if (out_instr !== 32'(i)) begin n_err++; $display("FAIL wrap_instr %0d: got %h expected %h", i, out_instr, 32'(i)); end
         n_cmp++; if (out_npc !== 32'(4 * i)) begin n_err++; $display("FAIL wrap_npc %0d: got %0d expected %0d", i, out_npc, 4 * i); end
         n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL wrap_count %0d: got %0d expected 1", i, count); end
      end
      push_valid = 1'b0;
      step();
      pop = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL wrap_final_valid: got %b expected 0", out_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      push_one(32'hA0000001, 32'd4);
      push_one(32'hA0000002, 32'd8);
      push_one(32'hA0000003, 32'd12);
      n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL flush_pre_count: got %0d expected 3", count); end
      flush = 1'b1; pop = 1'b1; push_valid = 1'b1; push_instr = 32'h11111111; push_npc = 32'd16;
      step();
      idle_inputs();
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d expected 0", count); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (out_instr === 32'h11111111) begin n_err++; $display("FAIL flush_leak cyc%0d: got %h expected not 11111111", i, out_instr); end
         step();
      end
      // flush on an empty queue is invisible
      flush = 1'b1;
      step();
      flush = 1'b0;
      n_cmp++; if (push_ready !== 1'b1 || count !== 3'd0) begin n_err++; $display("FAIL flush_empty: got ready=%b count=%0d expected ready=1 count=0", push_ready, count); end
      push_one(32'hB0000001, 32'd100);
      n_cmp++; if (out_instr !== 32'hB0000001) begin n_err++; $display("FAIL flush_resume: got %h expected b0000001", out_instr); end
   endtask

   task automatic test_full_push_pop();
      do_reset();
      for (int i = 1; i <= 4; i++) push_one(32'hC000_0000 + 32'(i), 32'(4 * i));
      n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fpp_pre_count: got %0d expected 4", count); end
      push_valid = 1'b1; push_instr = 32'h55555555; push_npc = 32'd99; pop = 1'b1;
      step();
      idle_inputs();
      n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL fpp_count: got %0d expected 3", count); end
      n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL fpp_overflow: got %b expected 1", overflow_err); end
      n_cmp++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL fpp_push_ready: got %b expected 1", push_ready); end
      pop = 1'b1;
      for (int i = 2; i <= 4; i++) begin
         n_cmp++; if (out_instr !== 32'hC000_0000 + 32'(i)) begin n_err++; $display("FAIL fpp_drain %0d: got %h expected %h", i, out_instr, 32'hC000_0000 + 32'(i)); end
         step();
      end
      pop = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fpp_empty: got %b expected 0", out_valid); end
   endtask

   task automatic test_async_reset();
      do_reset();
      push_one(32'hD0000001, 32'd4);
      push_one(32'hD0000002, 32'd8);
      n_cmp++; if (count !== 3'd2) begin n_err++; $display("FAIL async_pre_count: got %0d expected 2", count); end
      #2;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL async_out_valid: got %b expected 0", out_valid); end
      n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL async_count: got %0d expected 0", count); end
      n_cmp++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL async_out_instr: got %h expected 00000000", out_instr); end
      step();
      rst_n = 1'b1;
      step();
      n_cmp++; if (push_ready !== 1'b1) begin n_err++; $display("FAIL async_release_ready: got %b expected 1", push_ready); end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b1;
      idle_inputs();
      test_reset();
      test_fill_drain();
      test_wrap();
      test_flush();
      test_full_push_pop();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
